// File: rtl/beep_pattern_gen.sv
// beep_pattern_gen
// Turns a multi-bit beep code into a timed burst of N beeps (N = code value).
// Each beep is ON_UNITS time units of sound followed by OFF_UNITS units of
// silence, where one unit is UNIT_CYCLES clock cycles. A single pending code
// can be queued while a pattern is playing (newest request wins). Changing the
// code to 0 aborts everything immediately.
//
// Optional feature: define BEEP_TONE_EN for a passive buzzer. The ON phase then
// carries a square wave with a half-period of TONE_DIV cycles. Without the
// macro the buzzer output is held high for the whole ON phase.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   flag_beep  requested beep count, 0 = silence/abort
//   beep       buzzer drive, active high, registered
//   busy       high while a pattern is in progress
//   done       one-cycle pulse after a pattern completes normally

module beep_pattern_gen #(
  parameter int CODE_W      = 3,
  parameter int UNIT_CYCLES = 10_000_000,
  parameter int ON_UNITS    = 1,
  parameter int OFF_UNITS   = 1,
  parameter int TONE_DIV    = 12_500
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CODE_W-1:0] flag_beep,
  output logic              beep,
  output logic              busy,
  output logic              done
);

  localparam int UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int PH_MAX = (ON_UNITS > OFF_UNITS) ? ON_UNITS : OFF_UNITS;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [PH_W-1:0]   ON_LAST   = PH_W'(ON_UNITS - 1);
  localparam logic [PH_W-1:0]   OFF_LAST  = PH_W'(OFF_UNITS - 1);

  // Refuse to elaborate with a parameter set that would give zero-length phases.
  if (CODE_W < 1 || UNIT_CYCLES < 1 || ON_UNITS < 1 || OFF_UNITS < 1 || TONE_DIV < 1) begin : g_bad_cfg
    $error("beep_pattern_gen: all parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] flag_q;
  logic [CODE_W-1:0] beep_left_q, beep_left_d;
  logic [UNIT_W-1:0] unit_cnt_q, unit_cnt_d;
  logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic [CODE_W-1:0] pend_code_q, pend_code_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              beep_q, beep_d;

  logic trigger;
  logic abort;
  logic unit_tick;

  // A request is an edge on the code: any change to a nonzero value starts a
  // pattern, a change to zero aborts. Holding a value never re-triggers.
  assign trigger   = (flag_beep != flag_q) && (flag_beep != '0);
  assign abort     = (flag_beep != flag_q) && (flag_beep == '0);
  assign unit_tick = (state_q != IDLE) && (unit_cnt_q == UNIT_LAST);

  // Sequencer: unit prescaler, per-state unit counter, beep countdown and the
  // one-deep pending buffer. Abort is applied last so it overrides everything,
  // including a completion in the same cycle.
  always_comb begin
    state_d     = state_q;
    beep_left_d = beep_left_q;
    unit_cnt_d  = unit_cnt_q;
    phase_cnt_d = phase_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    done_d      = 1'b0;

    if (state_q != IDLE) begin
      unit_cnt_d = unit_tick ? '0 : unit_cnt_q + UNIT_W'(1);
      if (unit_tick) begin
        phase_cnt_d = phase_cnt_q + PH_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        // A fresh trigger beats a queued code; the queued one is dropped.
        if (trigger) begin
          state_d     = ON;
          beep_left_d = flag_beep;
          unit_cnt_d  = '0;
          phase_cnt_d = '0;
          pend_vld_d  = 1'b0;
        end else if (pend_vld_q) begin
          state_d     = ON;
          beep_left_d = pend_code_q;
          unit_cnt_d  = '0;
          phase_cnt_d = '0;
          pend_vld_d  = 1'b0;
        end
      end
      ON: begin
        if (unit_tick && phase_cnt_q == ON_LAST) begin
          state_d     = GAP;
          phase_cnt_d = '0;
        end
      end
      GAP: begin
        if (unit_tick && phase_cnt_q == OFF_LAST) begin
          phase_cnt_d = '0;
          if (beep_left_q > CODE_W'(1)) begin
            beep_left_d = beep_left_q - CODE_W'(1);
            state_d     = ON;
          end else begin
            beep_left_d = '0;
            state_d     = IDLE;
            done_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New requests during a pattern are parked, overwriting any older one.
    if (trigger && state_q != IDLE) begin
      pend_code_d = flag_beep;
      pend_vld_d  = 1'b1;
    end

    if (abort) begin
      state_d     = IDLE;
      beep_left_d = '0;
      unit_cnt_d  = '0;
      phase_cnt_d = '0;
      pend_vld_d  = 1'b0;
      done_d      = 1'b0;
    end
  end

`ifdef BEEP_TONE_EN
  localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;

  // Square wave restarted high on every ON entry so each beep sounds the same;
  // the output level flips each time the half-period counter wraps.
  always_comb begin
    tone_cnt_d = '0;
    beep_d     = 1'b0;
    if (state_d == ON) begin
      if (state_q != ON) begin
        tone_cnt_d = '0;
        beep_d     = 1'b1;
      end else if (tone_cnt_q == TONE_LAST) begin
        tone_cnt_d = '0;
        beep_d     = ~beep_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TONE_W'(1);
        beep_d     = beep_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tone_cnt_q <= '0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
    end
  end
`else
  // Active buzzer: the drive is simply the registered ON state.
  always_comb begin
    beep_d = (state_d == ON);
  end
`endif

  // All state and outputs are registered from the next-state values so the
  // buzzer pin and status flags change cleanly on the clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      flag_q      <= '0;
      beep_left_q <= '0;
      unit_cnt_q  <= '0;
      phase_cnt_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_q      <= flag_beep;
      beep_left_q <= beep_left_d;
      unit_cnt_q  <= unit_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
      beep_q      <= beep_d;
    end
  end

  assign beep = beep_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// tb_beep_pattern_gen
// Directed bench for beep_pattern_gen with short timing parameters
// (10-cycle unit, 2 units on, 1 unit off, tone half-period 2). Expected
// busy/beep/done traces are built from the pattern timing: a pattern of N
// beeps starting at sample s is busy for N*30 samples, sounds for the first
// 20 samples of every 30, and pulses done on the sample right after.
// Build with BEEP_TONE_EN defined to check the passive-buzzer waveform.

module tb_beep_pattern_gen;

  localparam int CodeW      = 3;
  localparam int UnitCycles = 10;
  localparam int OnUnits    = 2;
  localparam int OffUnits   = 1;
  localparam int ToneDiv    = 2;
  localparam int OnCycles   = OnUnits * UnitCycles;
  localparam int BeepPeriod = (OnUnits + OffUnits) * UnitCycles;
  localparam int Never      = 1_000_000;

`ifdef BEEP_TONE_EN
  localparam bit ToneEn = 1'b1;
`else
  localparam bit ToneEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [CodeW-1:0] flag_beep = '0;
  logic             beep;
  logic             busy;
  logic             done;

  int checkCount = 0;
  int errorCount = 0;

  // Schedule used by runWindow: up to two expected patterns, up to two input
  // changes, and a sample index from which everything must be silent (abort).
  int             segAStart, segANum, segBStart, segBNum, cutAt, chg1At, chg2At;
  logic [CodeW-1:0] chg1Val, chg2Val;

  beep_pattern_gen #(
    .CODE_W      (CodeW),
    .UNIT_CYCLES (UnitCycles),
    .ON_UNITS    (OnUnits),
    .OFF_UNITS   (OffUnits),
    .TONE_DIV    (ToneDiv)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flag_beep (flag_beep),
    .beep      (beep),
    .busy      (busy),
    .done      (done)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Expected {busy, beep, done} at sample k for an N-beep pattern whose first
  // busy sample is s.
  function automatic logic [2:0] segExpect(input int k, input int s, input int n);
    logic [2:0] e;
    int         len;
    int         p;
    e   = 3'b000;
    len = n * BeepPeriod;
    if (n > 0) begin
      if (k >= s && k < s + len) begin
        p    = (k - s) % BeepPeriod;
        e[2] = 1'b1;
        if (p < OnCycles) begin
          e[1] = ToneEn ? (((p / ToneDiv) % 2) == 0) : 1'b1;
        end
      end
      if (k == s + len) begin
        e[0] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic clearSchedule();
    segAStart = 0;
    segANum   = 0;
    segBStart = 0;
    segBNum   = 0;
    cutAt     = Never;
    chg1At    = Never;
    chg2At    = Never;
    chg1Val   = '0;
    chg2Val   = '0;
  endtask

  // Drive a new code just after a rising edge; the DUT sees it on the next one.
  task automatic applyStimulus(input logic [CodeW-1:0] code);
    @(posedge clk);
    #1 flag_beep = code;
  endtask

  // Sample k is taken on the falling edge following the k-th rising edge after
  // the stimulus; scheduled input changes go in just after that rising edge.
  task automatic runWindow(input string name, input int len);
    logic [2:0] e;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (k == chg1At) flag_beep = chg1Val;
      if (k == chg2At) flag_beep = chg2Val;
      @(negedge clk);
      e = segExpect(k, segAStart, segANum) | segExpect(k, segBStart, segBNum);
      if (k >= cutAt) e = 3'b000;
      checkOutput($sformatf("%s busy k=%0d", name, k), {31'd0, busy}, {31'd0, e[2]});
      checkOutput($sformatf("%s beep k=%0d", name, k), {31'd0, beep}, {31'd0, e[1]});
      checkOutput($sformatf("%s done k=%0d", name, k), {31'd0, done}, {31'd0, e[0]});
    end
  endtask

  initial begin
    // Reset held with a nonzero code present: outputs stay quiet.
    rstn      = 1'b0;
    flag_beep = 3'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset beep", {31'd0, beep}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);

    // Release with the code still 3: one 3-beep pattern, then no restart.
    @(posedge clk);
    #1 rstn = 1'b1;
    clearSchedule();
    segAStart = 1;
    segANum   = 3;
    runWindow("release", 96);

    applyStimulus(3'd0);
    clearSchedule();
    runWindow("idle_a", 3);

    // Plain 3-beep pattern from 0.
    applyStimulus(3'd3);
    clearSchedule();
    segAStart = 1;
    segANum   = 3;
    runWindow("three", 93);

    applyStimulus(3'd0);
    clearSchedule();
    runWindow("idle_b", 2);

    // Single beep: constant on, or tone waveform when BEEP_TONE_EN is set.
    applyStimulus(3'd1);
    clearSchedule();
    segAStart = 1;
    segANum   = 1;
    runWindow("single", 33);

    applyStimulus(3'd0);
    clearSchedule();
    runWindow("idle_c", 2);

    // Pending: 5 queued during a 2-beep pattern plays after one idle cycle.
    applyStimulus(3'd2);
    clearSchedule();
    segAStart = 1;
    segANum   = 2;
    chg1At    = 15;
    chg1Val   = 3'd5;
    segBStart = 62;
    segBNum   = 5;
    runWindow("pending", 215);

    applyStimulus(3'd0);
    clearSchedule();
    runWindow("idle_d", 2);

    // Abort: code 4 queued, then 0 kills the pattern and the queue, no done.
    applyStimulus(3'd7);
    clearSchedule();
    segAStart = 1;
    segANum   = 7;
    chg1At    = 10;
    chg1Val   = 3'd4;
    chg2At    = 25;
    chg2Val   = 3'd0;
    cutAt     = 26;
    runWindow("abort", 70);

    // Max code, held afterwards without restarting.
    applyStimulus(3'd7);
    clearSchedule();
    segAStart = 1;
    segANum   = 7;
    runWindow("max7", 231);

    // Changing 7 to 6 is a new request.
    applyStimulus(3'd6);
    clearSchedule();
    segAStart = 1;
    segANum   = 6;
    runWindow("six", 183);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
